// File: rtl/hwpe_ctrl_job_queue.sv
// Multi-context job scheduler for the HWPE control slave. Cores acquire,
// program and commit job contexts; committed jobs start the engine in order.
module hwpe_ctrl_job_queue #(
    parameter int unsigned N_CONTEXT     = 2,
    parameter int unsigned N_CORES       = 16,
    parameter int unsigned ID_WIDTH      = 8,
    parameter bit          EVT_BROADCAST = 1'b0,
    localparam int unsigned CTX_W        = $clog2(N_CONTEXT),
    localparam int unsigned CORE_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                acquire_req_i,
    input  logic [CORE_W-1:0]   acquire_core_i,
    output logic                acquire_gnt_o,
    output logic [ID_WIDTH-1:0] acquire_id_o,
    input  logic                commit_i,
    input  logic                done_i,
    output logic                start_o,
    output logic                is_working_o,
    output logic [CTX_W-1:0]    pointer_ctx_o,
    output logic [CTX_W-1:0]    running_ctx_o,
    output logic [N_CONTEXT-1:0] ctx_busy_o,
    output logic [N_CORES-1:0]  evt_o
);

    typedef enum logic [1:0] {
        CTX_FREE,
        CTX_ACQUIRED,
        CTX_QUEUED,
        CTX_RUNNING
    } ctx_state_e;

    typedef enum logic {
        ENG_IDLE,
        ENG_BUSY
    } eng_state_e;

    ctx_state_e          ctx_q   [N_CONTEXT];
    ctx_state_e          ctx_d   [N_CONTEXT];
    logic [CORE_W-1:0]   owner_q [N_CONTEXT];
    logic [CORE_W-1:0]   owner_d [N_CONTEXT];
    logic                lock_q, lock_d;
    logic [CTX_W-1:0]    ptr_q, ptr_d;
    logic [CTX_W-1:0]    run_q, run_d;
    logic [ID_WIDTH-1:0] jid_q, jid_d;
    eng_state_e          eng_q, eng_d;
    logic [N_CORES-1:0]  evt_q, evt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_CONTEXT; i++) begin
                ctx_q[i]   <= CTX_FREE;
                owner_q[i] <= '0;
            end
            lock_q <= 1'b0;
            ptr_q  <= '0;
            run_q  <= '0;
            jid_q  <= '0;
            eng_q  <= ENG_IDLE;
            evt_q  <= '0;
        end else begin
            ctx_q   <= ctx_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            run_q   <= run_d;
            jid_q   <= jid_d;
            eng_q   <= eng_d;
            evt_q   <= evt_d;
        end
    end

    // Acquire/commit touch ctx[ptr], start/done touch ctx[run]; these never
    // alias in the same cycle, so the updates are applied independently.
    always_comb begin
        ctx_d   = ctx_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        run_d   = run_q;
        jid_d   = jid_q;
        eng_d   = eng_q;
        evt_d   = '0;
        if (clear_i) begin
            for (int unsigned i = 0; i < N_CONTEXT; i++) begin
                ctx_d[i]   = CTX_FREE;
                owner_d[i] = '0;
            end
            lock_d = 1'b0;
            ptr_d  = '0;
            run_d  = '0;
            jid_d  = '0;
            eng_d  = ENG_IDLE;
        end else begin
            if (acquire_gnt_o) begin
                ctx_d[ptr_q]   = CTX_ACQUIRED;
                owner_d[ptr_q] = acquire_core_i;
                lock_d         = 1'b1;
                jid_d          = jid_q + ID_WIDTH'(1);
            end
            if (commit_i && lock_q) begin
                ctx_d[ptr_q] = CTX_QUEUED;
                lock_d       = 1'b0;
                ptr_d        = ptr_q + CTX_W'(1);
            end
            if (start_o) begin
                ctx_d[run_q] = CTX_RUNNING;
                eng_d        = ENG_BUSY;
            end else if (eng_q == ENG_BUSY && done_i) begin
                ctx_d[run_q] = CTX_FREE;
                run_d        = run_q + CTX_W'(1);
                eng_d        = ENG_IDLE;
                if (EVT_BROADCAST) begin
                    evt_d = '1;
                end else begin
                    for (int unsigned i = 0; i < N_CORES; i++) begin
                        if (owner_q[run_q] == CORE_W'(i)) evt_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        acquire_gnt_o = acquire_req_i && !lock_q && (ctx_q[ptr_q] == CTX_FREE);
        acquire_id_o  = acquire_req_i ? jid_q : '0;
        start_o       = (eng_q == ENG_IDLE) && (ctx_q[run_q] == CTX_QUEUED);
        is_working_o  = (eng_q == ENG_BUSY);
        pointer_ctx_o = ptr_q;
        running_ctx_o = run_q;
        evt_o         = evt_q;
        for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            ctx_busy_o[i] = (ctx_q[i] != CTX_FREE);
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// Bench for hwpe_ctrl_job_queue: two configurations driven in parallel and
// compared against a job-count/FIFO reference model.
module tb_hwpe_ctrl_job_queue;

    logic clk = 1'b0;
    logic rst_n, clear, req, commit, done;
    logic [3:0] core;

    logic        gnt0, start0, work0;
    logic [7:0]  id0;
    logic [0:0]  ptr0, run0;
    logic [1:0]  busy0;
    logic [15:0] evt0;

    logic        gnt1, start1, work1;
    logic [1:0]  id1;
    logic [1:0]  ptr1, run1;
    logic [3:0]  busy1;
    logic [15:0] evt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hwpe_ctrl_job_queue #(
        .N_CONTEXT(2), .N_CORES(16), .ID_WIDTH(8), .EVT_BROADCAST(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .acquire_req_i(req), .acquire_core_i(core),
        .acquire_gnt_o(gnt0), .acquire_id_o(id0),
        .commit_i(commit), .done_i(done),
        .start_o(start0), .is_working_o(work0),
        .pointer_ctx_o(ptr0), .running_ctx_o(run0),
        .ctx_busy_o(busy0), .evt_o(evt0)
    );

    hwpe_ctrl_job_queue #(
        .N_CONTEXT(4), .N_CORES(16), .ID_WIDTH(2), .EVT_BROADCAST(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .acquire_req_i(req), .acquire_core_i(core),
        .acquire_gnt_o(gnt1), .acquire_id_o(id1),
        .commit_i(commit), .done_i(done),
        .start_o(start1), .is_working_o(work1),
        .pointer_ctx_o(ptr1), .running_ctx_o(run1),
        .ctx_busy_o(busy1), .evt_o(evt1)
    );

    // Reference model: a lock flag, a FIFO of committed owners, a running
    // flag and commit/done counters from which both pointers follow.
    int nctx  [2] = '{2, 4};
    int idmod [2] = '{256, 4};
    int bcast [2] = '{0, 1};
    int m_lock [2], m_acq_owner [2], m_qn [2], m_run [2], m_run_owner [2];
    int m_jid [2], m_commits [2], m_dones [2];
    int m_q [2][8];
    logic [15:0] m_evt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_lock[k] = 0; m_acq_owner[k] = 0; m_qn[k] = 0; m_run[k] = 0;
        m_run_owner[k] = 0; m_jid[k] = 0; m_commits[k] = 0; m_dones[k] = 0;
        m_evt[k] = '0;
    endtask

    function automatic logic [31:0] exp_busy(input int k);
        logic [31:0] r;
        int occ;
        r = '0;
        occ = m_run[k] + m_qn[k] + m_lock[k];
        for (int j = 0; j < occ; j++) r[(m_dones[k] + j) % nctx[k]] = 1'b1;
        return r;
    endfunction

    task automatic check_dut(input int k, input logic g, input logic [31:0] id,
                             input logic s, input logic w, input logic [31:0] p,
                             input logic [31:0] rc, input logic [31:0] b,
                             input logic [15:0] e);
        int n;
        n = nctx[k];
        check($sformatf("d%0d_gnt", k), 32'(g),
              32'(req && m_lock[k] == 0 && (m_run[k] + m_qn[k]) < n));
        check($sformatf("d%0d_id", k), id, req ? 32'(m_jid[k]) : 32'd0);
        check($sformatf("d%0d_start", k), 32'(s), 32'(m_run[k] == 0 && m_qn[k] > 0));
        check($sformatf("d%0d_working", k), 32'(w), 32'(m_run[k]));
        check($sformatf("d%0d_ptr", k), p, 32'(m_commits[k] % n));
        check($sformatf("d%0d_runctx", k), rc, 32'(m_dones[k] % n));
        check($sformatf("d%0d_busy", k), b, exp_busy(k));
        check($sformatf("d%0d_evt", k), 32'(e), 32'(m_evt[k]));
    endtask

    task automatic check_all();
        check_dut(0, gnt0, 32'(id0), start0, work0, 32'(ptr0), 32'(run0), 32'(busy0), evt0);
        check_dut(1, gnt1, 32'(id1), start1, work1, 32'(ptr1), 32'(run1), 32'(busy1), evt1);
    endtask

    task automatic model_update(input int k);
        int g, s, dn;
        if (clear) begin
            model_reset(k);
            return;
        end
        g  = int'(req && m_lock[k] == 0 && (m_run[k] + m_qn[k]) < nctx[k]);
        s  = int'(m_run[k] == 0 && m_qn[k] > 0);
        dn = int'(m_run[k] != 0 && done);
        m_evt[k] = '0;
        if (dn != 0) begin
            m_run[k] = 0;
            m_dones[k]++;
            m_evt[k] = (bcast[k] != 0) ? 16'hffff : (16'd1 << m_run_owner[k]);
        end
        if (s != 0) begin
            m_run_owner[k] = m_q[k][0];
            for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
            m_qn[k]--;
            m_run[k] = 1;
        end
        if (commit && m_lock[k] != 0) begin
            m_q[k][m_qn[k]] = m_acq_owner[k];
            m_qn[k]++;
            m_lock[k] = 0;
            m_commits[k]++;
        end
        if (g != 0) begin
            m_lock[k] = 1;
            m_acq_owner[k] = int'(core);
            m_jid[k] = (m_jid[k] + 1) % idmod[k];
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later
    // and the model advances to mirror the following rising edge.
    task automatic step(input logic r, input logic [3:0] c, input logic cm,
                        input logic d, input logic cl);
        @(negedge clk);
        req = r; core = c; commit = cm; done = d; clear = cl;
        #1;
        check_all();
        model_update(0);
        model_update(1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req = 1'b0; commit = 1'b0; done = 1'b0; clear = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; req = 1'b0; commit = 1'b0; done = 1'b0; core = '0;
        model_reset(0);
        model_reset(1);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single job from core 3
        step(1, 4'd3, 0, 0, 0);
        check("plan_gnt", 32'(gnt0), 32'd1);
        check("plan_id", 32'(id0), 32'd0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("plan_start", 32'(start0), 32'd1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("plan_evt_owner", 32'(evt0), 32'h0008);
        check("plan_evt_bcast", 32'(evt1), 32'hffff);
        check("plan_busy_clear", 32'(busy0), 32'd0);
        step(0, 0, 0, 0, 0);
        check("plan_evt_once", 32'(evt0), 32'd0);

        // Lock: second acquire while the first is uncommitted
        step(1, 4'd1, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0);
        check("plan_lock_gnt", 32'(gnt0), 32'd0);
        step(1, 4'd2, 1, 0, 0);
        check("plan_acq_commit_gnt", 32'(gnt0), 32'd0);
        step(0, 0, 1, 0, 0);

        // Random traffic with occasional soft clear and async reset
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) async_reset();
            step(logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_job_queue.md
Name: hwpe_ctrl_job_queue

Overview:
- Parametrised multi-context job scheduler for the HWPE control slave. It generalises the fixed acquire/commit/trigger logic to N_CONTEXT job slots.
- Cores acquire a context, program it, then commit it. The block queues committed jobs in order and starts the engine once per job.
- On engine done it frees the context and sends a completion event to the owning core. It sits between the register-file decoder and the engine FSM.

Parameters:
- N_CONTEXT, 2, number of job contexts; power of two, 2..8.
- N_CORES, 16, number of offloading cores; 1..16.
- ID_WIDTH, 8, job-ID counter width.
- EVT_BROADCAST, 0, 1 = completion event pulses all cores instead of only the owner.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low.
- clear_i  in  1  synchronous soft clear.
- acquire_req_i  in  1  acquire request (read of the ACQUIRE register).
- acquire_core_i  in  max(1,$clog2(N_CORES))  requesting core ID.
- acquire_gnt_o  out  1  acquire accepted this cycle (combinational).
- acquire_id_o  out  ID_WIDTH  job ID returned to the core (combinational).
- commit_i  in  1  commit the currently acquired context.
- done_i  in  1  engine finished the running job.
- start_o  out  1  one-cycle engine start pulse.
- is_working_o  out  1  engine busy.
- pointer_ctx_o  out  $clog2(N_CONTEXT)  context being programmed or next to acquire.
- running_ctx_o  out  $clog2(N_CONTEXT)  context at the queue head.
- ctx_busy_o  out  N_CONTEXT  per-context non-FREE flag.
- evt_o  out  N_CORES  completion event pulses.

Behaviour:
- Per-context state: FREE, ACQUIRED, QUEUED or RUNNING. Each context also stores a 2-bit state and an owner core ID.
- Registered globals: lock, pointer_ctx, running_ctx, job_id, engine FSM (IDLE/BUSY), evt register.
- Reset and clear_i produce the same state:
  - all contexts FREE, lock 0, both pointers 0, job_id 0, FSM IDLE, evt_o 0;
  - start_o 0, is_working_o 0, acquire_gnt_o 0.
- clear_i has priority over all other inputs in the same cycle.
- Acquire:
  - acquire_gnt_o = acquire_req_i && !lock && ctx[pointer_ctx]==FREE, evaluated on registered state only.
  - acquire_id_o = job_id, driven whenever acquire_req_i is high.
  - On grant at the next edge: ctx[pointer_ctx] becomes ACQUIRED, owner = acquire_core_i, lock = 1, job_id = job_id+1 modulo 2^ID_WIDTH.
  - A rejected acquire has no side effects.
- Commit:
  - If lock=1: ctx[pointer_ctx] becomes QUEUED, lock = 0, pointer_ctx = pointer_ctx+1 modulo N_CONTEXT.
  - If lock=0: commit_i is ignored.
- Engine FSM:
  - start_o = (FSM==IDLE) && ctx[running_ctx]==QUEUED. This is combinational from registers only.
  - When start_o is high: ctx[running_ctx] becomes RUNNING and the FSM goes to BUSY at the next edge.
  - BUSY with done_i: ctx[running_ctx] becomes FREE, running_ctx = running_ctx+1 modulo N_CONTEXT, FSM goes to IDLE.
  - done_i is ignored in IDLE.
- Completion event:
  - evt_o pulses in the cycle after done_i, for exactly one cycle.
  - The pulse is one-hot on the owner bit, or all ones when EVT_BROADCAST=1.
- is_working_o = (FSM==BUSY).
- Latencies:
  - commit at cycle t gives start_o at t+1 if the engine is idle and the queue was empty.
  - done at t gives start_o at t+1 if the next context is QUEUED, and evt_o at t+1.
- Simultaneous events:
  - acquire+commit in one cycle: the acquire is rejected because lock is still set.
  - done+acquire in one cycle: the freed context is not visible to the acquire until t+1.
  - commit+done in one cycle: both updates are applied.
- Full queue: when all contexts are non-FREE, ctx[pointer_ctx] is not FREE, so every acquire is rejected.
- Reset asserted mid-job: all state returns to the reset values asynchronously and no evt_o is produced.

Test Plan:
- Single job: acquire from core 3 → gnt=1, id=0. Commit → start_o at the next cycle. done_i → evt_o=16'h0008 one cycle later, ctx_busy_o=0.
- Fill queue (N_CONTEXT=2), engine held busy: two acquire+commit pairs succeed with ids 0 and 1. A third acquire → gnt=0 and id stays 2. After done, the next acquire gets id=2.
- Lock: acquire from core 1 with no commit, then acquire from core 2 → gnt=0. A commit_i with no lock held is ignored.
- Back-to-back: with two jobs QUEUED, done_i at t → start_o at t+1, running_ctx 0→1 and wraps to 0 after the second done.
- ID wrap: ID_WIDTH=2, five grants → ids 0,1,2,3,0.
- EVT_BROADCAST=1: done → evt_o=all ones for one cycle. clear_i mid-job → all outputs at reset values the next cycle, no event.
